// File: rtl/uart_frame_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_frame_loader_if
//  Description : Byte-in / frame-buffer-out bundle for uart_frame_loader.
//                The "master" side is the loader itself; "slave" is whoever
//                feeds UART bytes and consumes writes and status.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_frame_loader_if #(
    parameter int PIX_W  = 12,
    parameter int ADDR_W = 15
);
    logic [7:0]        i_rx_data;
    logic              i_rx_done;
    logic              o_wr_en;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [PIX_W-1:0]  o_wr_data;
    logic              o_pkt_ok;
    logic              o_pkt_err;
    logic              o_frame_done;
    logic [7:0]        o_status;

    modport master (
        input  i_rx_data, i_rx_done,
        output o_wr_en, o_wr_addr, o_wr_data,
        output o_pkt_ok, o_pkt_err, o_frame_done, o_status
    );

    modport slave (
        output i_rx_data, i_rx_done,
        input  o_wr_en, o_wr_addr, o_wr_data,
        input  o_pkt_ok, o_pkt_err, o_frame_done, o_status
    );
endinterface
`default_nettype wire

// File: rtl/uart_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module      : uart_frame_loader
//  Description : Frames UART bytes into checksummed packets
//                (SYNC0 SYNC1 CMD LEN_H LEN_L PAYLOAD CHK) and writes packed
//                big-endian pixels into the frame buffer. CMD 01 = pixels,
//                CMD 02 = set write pointer.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_loader #(
    parameter int          PIX_W       = 12,
    parameter int          H_RES       = 160,
    parameter int          V_RES       = 120,
    parameter int          ADDR_W      = 15,
    parameter int          MAX_LEN     = 1024,
    parameter logic [7:0]  SYNC0       = 8'h55,
    parameter logic [7:0]  SYNC1       = 8'hAA,
    parameter int          TIMEOUT_CYC = 521000
) (
    input  logic                 i_clk_sys,
    input  logic                 i_rst_n,
    uart_frame_loader_if.master  bus
);

    localparam int                TMO_W      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0]  c_tmo_last = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [ADDR_W-1:0] c_last_pix = ADDR_W'(H_RES * V_RES - 1);
    localparam logic [31:0]       c_npix     = 32'(H_RES * V_RES);
    localparam logic [31:0]       c_max_len  = 32'(MAX_LEN);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_SYNC = 4'd1,
        S_CMD  = 4'd2,
        S_LENH = 4'd3,
        S_LENL = 4'd4,
        S_PAY  = 4'd5,
        S_CHK  = 4'd6
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [TMO_W-1:0]  r_tmo;
    logic              r_is_pix;        // current packet is CMD 01
    logic [7:0]        r_len_h;
    logic [15:0]       r_cnt;           // payload bytes still to come
    logic [7:0]        r_sum;
    logic              r_lo_phase;      // next pixel byte is the low byte
    logic [7:0]        r_hi;
    logic [15:0]       r_addr_buf;
    logic [ADDR_W-1:0] r_ptr;
    logic [3:0]        r_err_cnt;

    logic              r_wr_en, r_pkt_ok, r_pkt_err, r_frame_done;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [PIX_W-1:0]  r_wr_data;

    logic              w_wr, w_ok, w_err, w_load, w_tmo;
    logic [15:0]       w_len;
    logic [15:0]       w_word;

    assign w_len  = {r_len_h, bus.i_rx_data};
    assign w_word = {r_hi, bus.i_rx_data};

    // State register
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state decode plus one-cycle event requests; a byte always beats a timeout
    always_comb begin
        w_state_nxt = r_state;
        w_wr        = 1'b0;
        w_ok        = 1'b0;
        w_err       = 1'b0;
        w_load      = 1'b0;
        w_tmo       = 1'b0;
        if (bus.i_rx_done) begin
            case (r_state)
                S_IDLE: if (bus.i_rx_data == SYNC0) w_state_nxt = S_SYNC;
                S_SYNC: begin
                    if (bus.i_rx_data == SYNC1)      w_state_nxt = S_CMD;
                    else if (bus.i_rx_data != SYNC0) w_state_nxt = S_IDLE;
                end
                S_CMD: begin
                    if (bus.i_rx_data == 8'h01 || bus.i_rx_data == 8'h02) begin
                        w_state_nxt = S_LENH;
                    end else begin
                        w_err       = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                S_LENH: w_state_nxt = S_LENL;
                S_LENL: begin
                    if (({16'd0, w_len} > c_max_len) ||
                        (r_is_pix && w_len[0]) ||
                        (!r_is_pix && w_len != 16'd2)) begin
                        w_err       = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else if (w_len == 16'd0) begin
                        w_state_nxt = S_CHK;
                    end else begin
                        w_state_nxt = S_PAY;
                    end
                end
                S_PAY: begin
                    w_wr = r_is_pix && r_lo_phase;
                    if (r_cnt == 16'd1) w_state_nxt = S_CHK;
                end
                S_CHK: begin
                    w_state_nxt = S_IDLE;
                    if (bus.i_rx_data != r_sum) begin
                        w_err = 1'b1;
                    end else if (!r_is_pix && ({16'd0, r_addr_buf} >= c_npix)) begin
                        w_err = 1'b1;
                    end else begin
                        w_ok   = 1'b1;
                        w_load = !r_is_pix;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end else if (r_state != S_IDLE && r_tmo == c_tmo_last) begin
            w_tmo       = 1'b1;
            w_err       = 1'b1;
            w_state_nxt = S_IDLE;
        end
    end

    // Packet datapath: checksum, length, pixel assembly, pointer, pulses, errors
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tmo        <= '0;
            r_is_pix     <= 1'b0;
            r_len_h      <= '0;
            r_cnt        <= '0;
            r_sum        <= '0;
            r_lo_phase   <= 1'b0;
            r_hi         <= '0;
            r_addr_buf   <= '0;
            r_ptr        <= '0;
            r_err_cnt    <= '0;
            r_wr_en      <= 1'b0;
            r_pkt_ok     <= 1'b0;
            r_pkt_err    <= 1'b0;
            r_frame_done <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
        end else begin
            r_wr_en      <= w_wr;
            r_pkt_ok     <= w_ok;
            r_pkt_err    <= w_err;
            r_frame_done <= w_wr && (r_ptr == c_last_pix);

            if (w_wr) begin
                r_wr_addr <= r_ptr;
                r_wr_data <= w_word[PIX_W-1:0];
                r_ptr     <= (r_ptr == c_last_pix) ? '0 : r_ptr + 1'b1;
            end else if (w_load) begin
                r_ptr <= ADDR_W'(r_addr_buf);
            end

            if (w_err && r_err_cnt != 4'hF) r_err_cnt <= r_err_cnt + 4'd1;

            if (r_state == S_IDLE || bus.i_rx_done || w_tmo) r_tmo <= '0;
            else                                              r_tmo <= r_tmo + 1'b1;

            if (bus.i_rx_done) begin
                case (r_state)
                    S_CMD: begin
                        r_is_pix <= (bus.i_rx_data == 8'h01);
                        r_sum    <= bus.i_rx_data;
                    end
                    S_LENH: begin
                        r_len_h <= bus.i_rx_data;
                        r_sum   <= r_sum + bus.i_rx_data;
                    end
                    S_LENL: begin
                        r_cnt      <= w_len;
                        r_lo_phase <= 1'b0;
                        r_sum      <= r_sum + bus.i_rx_data;
                    end
                    S_PAY: begin
                        r_cnt <= r_cnt - 16'd1;
                        r_sum <= r_sum + bus.i_rx_data;
                        if (r_is_pix) begin
                            r_lo_phase <= !r_lo_phase;
                            if (!r_lo_phase) r_hi <= bus.i_rx_data;
                        end else begin
                            r_addr_buf <= {r_addr_buf[7:0], bus.i_rx_data};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.o_wr_en      = r_wr_en;
    assign bus.o_wr_addr    = r_wr_addr;
    assign bus.o_wr_data    = r_wr_data;
    assign bus.o_pkt_ok     = r_pkt_ok;
    assign bus.o_pkt_err    = r_pkt_err;
    assign bus.o_frame_done = r_frame_done;
    assign bus.o_status     = {r_err_cnt, r_state};

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_frame_loader
//  Description : Scoreboard bench for uart_frame_loader. Stimulus pushes the
//                expected writes / ok / err events; a negedge monitor pops
//                and compares each event the DUT presents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_frame_loader;

    localparam int PIX_W  = 12;
    localparam int ADDR_W = 15;
    localparam int TMO    = 50;

    localparam logic [1:0] K_WR  = 2'd0;
    localparam logic [1:0] K_OK  = 2'd1;
    localparam logic [1:0] K_ERR = 2'd2;

    typedef struct packed {
        logic [1:0]        kind;
        logic [ADDR_W-1:0] addr;
        logic [PIX_W-1:0]  data;
        logic              fd;
        logic [7:0]        status;
    } ev_t;

    logic clk;
    logic rst_n;
    uart_frame_loader_if #(.PIX_W(PIX_W), .ADDR_W(ADDR_W)) bus ();

    uart_frame_loader #(
        .PIX_W(PIX_W), .H_RES(160), .V_RES(120), .ADDR_W(ADDR_W),
        .MAX_LEN(1024), .SYNC0(8'h55), .SYNC1(8'hAA), .TIMEOUT_CYC(TMO)
    ) dut (
        .i_clk_sys (clk),
        .i_rst_n   (rst_n),
        .bus       (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ev_t        sb[$];
    logic [7:0] pkt[$];
    int         n_vec  = 0;
    int         n_miss = 0;
    int         e_errs = 0;

    // Monitor: every DUT event consumes exactly one scoreboard entry
    always @(negedge clk) begin
        ev_t e;
        logic [1:0] k;
        if (bus.o_wr_en || bus.o_pkt_ok || bus.o_pkt_err || bus.o_frame_done) begin
            n_vec++;
            k = bus.o_wr_en ? K_WR : (bus.o_pkt_ok ? K_OK : K_ERR);
            if (bus.o_pkt_ok && bus.o_pkt_err) begin
                n_miss++;
                $display("FAIL ok_err_together: ok=%0b err=%0b, required not both", bus.o_pkt_ok, bus.o_pkt_err);
            end else if (sb.size() == 0) begin
                n_miss++;
                $display("FAIL unexpected_event: kind=%0d addr=%0d data=%h fd=%0b, required no event", k, bus.o_wr_addr, bus.o_wr_data, bus.o_frame_done);
            end else begin
                e = sb.pop_front();
                if (k != e.kind) begin
                    n_miss++;
                    $display("FAIL event_kind: got %0d, required %0d", k, e.kind);
                end else if (k == K_WR) begin
                    if (bus.o_wr_addr != e.addr || bus.o_wr_data != e.data || bus.o_frame_done != e.fd) begin
                        n_miss++;
                        $display("FAIL write: got addr=%0d data=%h fd=%0b, required addr=%0d data=%h fd=%0b", bus.o_wr_addr, bus.o_wr_data, bus.o_frame_done, e.addr, e.data, e.fd);
                    end
                end else if (bus.o_status != e.status || bus.o_frame_done) begin
                    n_miss++;
                    $display("FAIL pkt_status: kind=%0d got status=%h fd=%0b, required status=%h fd=0", k, bus.o_status, bus.o_frame_done, e.status);
                end
            end
        end
    end

    task automatic exp_wr(input int a, input logic [11:0] d, input logic fd);
        ev_t e;
        e.kind = K_WR; e.addr = ADDR_W'(a); e.data = d; e.fd = fd; e.status = '0;
        sb.push_back(e);
    endtask

    task automatic exp_ok();
        ev_t e;
        e.kind = K_OK; e.addr = '0; e.data = '0; e.fd = 1'b0; e.status = {4'(e_errs), 4'd0};
        sb.push_back(e);
    endtask

    task automatic exp_err();
        ev_t e;
        if (e_errs < 15) e_errs++;
        e.kind = K_ERR; e.addr = '0; e.data = '0; e.fd = 1'b0; e.status = {4'(e_errs), 4'd0};
        sb.push_back(e);
    endtask

    // One strobe per byte, then gap idle clocks
    task automatic send(input logic [7:0] b, input int gap);
        bus.i_rx_data = b;
        bus.i_rx_done = 1'b1;
        @(posedge clk); #1;
        bus.i_rx_done = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
    endtask

    task automatic send_pkt();
        while (pkt.size() > 0) send(pkt.pop_front(), 2);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_vec++;
        if (got !== req) begin
            n_miss++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic check_all_zero(input string name);
        check(name, {bus.o_wr_en, bus.o_pkt_ok, bus.o_pkt_err, bus.o_frame_done,
                     bus.o_status, 20'(bus.o_wr_addr)}, 32'd0);
        check({name, "_data"}, 32'(bus.o_wr_data), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.i_rx_data = '0;
        bus.i_rx_done = 1'b0;
        idle(3);
        check_all_zero("reset_outputs");
        rst_n = 1'b1;
        idle(2);

        // Basic two-pixel packet
        exp_wr(0, 12'hF00, 0); exp_wr(1, 12'h0F0, 0); exp_ok();
        pkt = '{8'h55, 8'hAA, 8'h01, 8'h00, 8'h04, 8'h0F, 8'h00, 8'h00, 8'hF0, 8'h04};
        send_pkt(); idle(3);

        // Set address to last pixel, write there (frame_done), then wrap to 0
        exp_ok();
        pkt = '{8'h55, 8'hAA, 8'h02, 8'h00, 8'h02, 8'h4A, 8'hFF, 8'h4D};
        send_pkt(); idle(3);
        exp_wr(19199, 12'hABC, 1); exp_ok();
        pkt = '{8'h55, 8'hAA, 8'h01, 8'h00, 8'h02, 8'h0A, 8'hBC, 8'hC9};
        send_pkt(); idle(3);
        exp_wr(0, 12'h123, 0); exp_ok();
        pkt = '{8'h55, 8'hAA, 8'h01, 8'h00, 8'h02, 8'h01, 8'h23, 8'h27};
        send_pkt(); idle(3);

        // Bad checksum: writes still land, then error
        exp_wr(1, 12'hF00, 0); exp_wr(2, 12'h0F0, 0); exp_err();
        pkt = '{8'h55, 8'hAA, 8'h01, 8'h00, 8'h04, 8'h0F, 8'h00, 8'h00, 8'hF0, 8'h05};
        send_pkt(); idle(3);
        check("status_after_chk_err", 32'(bus.o_status), 32'h10);

        // Odd length rejected on LEN_L
        exp_err();
        pkt = '{8'h55, 8'hAA, 8'h01, 8'h00, 8'h03};
        send_pkt(); idle(3);
        check("status_after_odd_len", 32'(bus.o_status), 32'h20);

        // Timeout after the high byte: exactly TMO idle clocks
        exp_err();
        pkt = '{8'h55, 8'hAA, 8'h01, 8'h00, 8'h02};
        send_pkt();
        send(8'h0F, TMO);
        idle(2);
        check("status_after_timeout", 32'(bus.o_status), 32'h30);

        // Byte arrives on the timeout clock: no error
        exp_wr(3, 12'hFED, 0); exp_ok();
        pkt = '{8'h55, 8'hAA, 8'h01, 8'h00, 8'h02};
        send_pkt();
        send(8'h0F, TMO - 1);
        send(8'hED, 2);
        send(8'hFF, 2);
        idle(3);
        check("status_after_late_byte", 32'(bus.o_status), 32'h30);

        // Repeated SYNC0 tolerated, unknown command rejected
        exp_err();
        pkt = '{8'h55, 8'h55, 8'hAA, 8'h03};
        send_pkt(); idle(3);

        // Address 19200 is out of range
        exp_err();
        pkt = '{8'h55, 8'hAA, 8'h02, 8'h00, 8'h02, 8'h4B, 8'h00, 8'h4F};
        send_pkt(); idle(3);
        check("status_after_bad_addr", 32'(bus.o_status), 32'h50);

        // Reset mid-payload: pointer back to 0
        exp_wr(4, 12'h122, 0);
        pkt = '{8'h55, 8'hAA, 8'h01, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33};
        send_pkt();
        check("mid_packet_state", 32'(bus.o_status[3:0]), 32'd5);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        e_errs = 0;
        idle(3);
        rst_n = 1'b1;
        idle(2);
        exp_wr(0, 12'hABC, 0); exp_ok();
        pkt = '{8'h55, 8'hAA, 8'h01, 8'h00, 8'h02, 8'h0A, 8'hBC, 8'hC9};
        send_pkt(); idle(5);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
